// File: rtl/i2c_target_regs.sv
// I2C target with a register-pointer protocol: an address byte, then a pointer byte,
// then data bytes that are written to or read from an 8-bit register port.
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h1A,
    parameter int         PTR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             sda_oe,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wdata,
    output logic             reg_we,
    input  logic [7:0]       reg_rdata,
    output logic             busy
);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_ADDR     = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK = 4'd2;
    localparam logic [3:0] ST_PTR      = 4'd3;
    localparam logic [3:0] ST_PTR_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA    = 4'd5;
    localparam logic [3:0] ST_DATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA    = 4'd7;
    localparam logic [3:0] ST_MACK     = 4'd8;
    localparam logic [3:0] ST_IGNORE   = 4'd9;

    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [1:0] scl_sync_r;
    logic [1:0] sda_sync_r;
    logic       scl_prev_r;
    logic       sda_prev_r;
    logic       scl_s;
    logic       sda_s;
    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic [7:0] byte_s;
    logic       last_bit_s;

    logic [3:0] state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       ack_hi_r;
    logic       rw_r;
    logic       mack_ok_r;

    // Two-flop synchronizers plus one history flop for edge detection (idle bus = 1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_r <= 2'b11;
            sda_sync_r <= 2'b11;
            scl_prev_r <= 1'b1;
            sda_prev_r <= 1'b1;
        end else begin
            scl_sync_r <= {scl_sync_r[0], scl_i};
            sda_sync_r <= {sda_sync_r[0], sda_i};
            scl_prev_r <= scl_sync_r[1];
            sda_prev_r <= sda_sync_r[1];
        end
    end

    assign scl_s      = scl_sync_r[1];
    assign sda_s      = sda_sync_r[1];
    assign scl_rise_s = scl_s & ~scl_prev_r;
    assign scl_fall_s = ~scl_s & scl_prev_r;
    assign start_s    = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
    assign stop_s     = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
    assign byte_s     = {shift_r[6:0], sda_s};
    assign last_bit_s = (bit_cnt_r == 3'd7);

    // Protocol FSM: START/STOP override every state; bits shift on SCL rise, SDA moves on SCL fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 3'd0;
            shift_r   <= 8'd0;
            ack_hi_r  <= 1'b0;
            rw_r      <= 1'b0;
            mack_ok_r <= 1'b0;
            sda_oe    <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 8'd0;
            reg_we    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            reg_we <= 1'b0;
            if (reg_we) begin
                reg_addr <= reg_addr + PTR_ONE;
            end else begin
                reg_addr <= reg_addr;
            end
            if (start_s) begin
                state_r   <= ST_ADDR;
                bit_cnt_r <= 3'd0;
                ack_hi_r  <= 1'b0;
                sda_oe    <= 1'b0;
                busy      <= 1'b0;
            end else if (stop_s) begin
                state_r  <= ST_IDLE;
                ack_hi_r <= 1'b0;
                sda_oe   <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        sda_oe <= 1'b0;
                    end
                    ST_ADDR: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (last_bit_s) begin
                                if (byte_s[7:1] == DEV_ADDR) begin
                                    state_r <= ST_ADDR_ACK;
                                    busy    <= 1'b1;
                                    rw_r    <= byte_s[0];
                                end else begin
                                    state_r <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_PTR_ACK, ST_DATA_ACK: begin
                        if (scl_fall_s) begin
                            if (!ack_hi_r) begin
                                sda_oe   <= 1'b1;
                                ack_hi_r <= 1'b1;
                            end else begin
                                ack_hi_r  <= 1'b0;
                                bit_cnt_r <= 3'd0;
                                if ((state_r == ST_ADDR_ACK) && rw_r) begin
                                    // First read byte is loaded on the same fall that ends the ACK.
                                    shift_r <= reg_rdata;
                                    sda_oe  <= ~reg_rdata[7];
                                    state_r <= ST_RDATA;
                                end else begin
                                    sda_oe  <= 1'b0;
                                    state_r <= (state_r == ST_ADDR_ACK) ? ST_PTR : ST_WDATA;
                                end
                            end
                        end
                    end
                    ST_PTR: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (last_bit_s) begin
                                reg_addr <= PTR_W'(byte_s);
                                state_r  <= ST_PTR_ACK;
                            end
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise_s) begin
                            shift_r   <= byte_s;
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            if (last_bit_s) begin
                                reg_wdata <= byte_s;
                                reg_we    <= 1'b1;
                                state_r   <= ST_DATA_ACK;
                            end
                        end
                    end
                    ST_RDATA: begin
                        if (scl_fall_s) begin
                            if (last_bit_s) begin
                                sda_oe    <= 1'b0;
                                reg_addr  <= reg_addr + PTR_ONE;
                                mack_ok_r <= 1'b0;
                                state_r   <= ST_MACK;
                            end else begin
                                shift_r   <= {shift_r[6:0], 1'b0};
                                sda_oe    <= ~shift_r[6];
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                            end
                        end
                    end
                    ST_MACK: begin
                        if (scl_rise_s) begin
                            if (sda_s) begin
                                state_r <= ST_IGNORE;
                            end else begin
                                mack_ok_r <= 1'b1;
                            end
                        end else if (scl_fall_s && mack_ok_r) begin
                            shift_r   <= reg_rdata;
                            sda_oe    <= ~reg_rdata[7];
                            bit_cnt_r <= 3'd0;
                            mack_ok_r <= 1'b0;
                            state_r   <= ST_RDATA;
                        end
                    end
                    ST_IGNORE: begin
                        sda_oe <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        sda_oe  <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: an I2C initiator model drives the bus, a register model answers reads,
// and every observation is compared with hand-computed values.
module tb_i2c_target_regs;

    localparam int Q = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_i;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] we_log[$];
    logic busy_seen = 1'b0;

    i2c_target_regs #(.DEV_ADDR(7'h1A), .PTR_W(8)) dut (
        .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_i), .sda_oe(sda_oe),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
        .reg_rdata(reg_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Open-drain bus: low if either side pulls.
    assign sda_i     = sda_m & ~sda_oe;
    assign reg_rdata = reg_addr ^ 8'h5A;

    always @(negedge clk) begin
        if (reg_we) we_log.push_back({reg_addr, reg_wdata});
        if (busy) busy_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bus_bit(input logic b, output logic s);
        repeat (Q) @(negedge clk);
        sda_m = b;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        s = sda_i;
        repeat (Q) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl = 1'b0;
    endtask

    task automatic bus_stop();
        repeat (Q) @(negedge clk);
        sda_m = 1'b0;
        repeat (Q) @(negedge clk);
        scl = 1'b1;
        repeat (Q) @(negedge clk);
        sda_m = 1'b1;
        repeat (2 * Q) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], s);
        bus_bit(1'b1, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, s);
            d[i] = s;
        end
        bus_bit(~mack, s);
    endtask

    initial begin
        logic       ack;
        logic       s;
        logic [7:0] rd;

        // Reset with idle bus
        repeat (4) @(negedge clk);
        chk("rst_sda_oe", 16'(sda_oe), 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_reg_addr", 16'(reg_addr), 16'h0);
        chk("rst_reg_we", 16'(reg_we), 16'h0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("post_rst_sda_oe", 16'(sda_oe), 16'h0);
        chk("post_rst_busy", 16'(busy), 16'h0);

        // Write: pointer 5, data A5, 3C
        bus_start();
        write_byte(8'h34, ack);
        chk("wr_addr_ack", 16'(ack), 16'h1);
        chk("wr_busy", 16'(busy), 16'h1);
        write_byte(8'h05, ack);
        chk("wr_ptr_ack", 16'(ack), 16'h1);
        chk("wr_ptr_val", 16'(reg_addr), 16'h05);
        write_byte(8'hA5, ack);
        chk("wr_d0_ack", 16'(ack), 16'h1);
        write_byte(8'h3C, ack);
        chk("wr_d1_ack", 16'(ack), 16'h1);
        bus_stop();
        chk("wr_busy_after_stop", 16'(busy), 16'h0);
        chk("wr_final_addr", 16'(reg_addr), 16'h07);
        chk("wr_we_count", 16'(we_log.size()), 16'd2);
        chk("wr_we0", we_log[0], 16'h05A5);
        chk("wr_we1", we_log[1], 16'h063C);

        // Combined read from pointer 0x10
        bus_start();
        write_byte(8'h34, ack);
        chk("rd_addr_w_ack", 16'(ack), 16'h1);
        write_byte(8'h10, ack);
        chk("rd_ptr_ack", 16'(ack), 16'h1);
        chk("rd_ptr_val", 16'(reg_addr), 16'h10);
        bus_start();
        write_byte(8'h35, ack);
        chk("rd_addr_r_ack", 16'(ack), 16'h1);
        read_byte(1'b1, rd);
        chk("rd_byte0", 16'(rd), 16'h4A);
        read_byte(1'b0, rd);
        chk("rd_byte1", 16'(rd), 16'h4B);
        chk("rd_sda_released", 16'(sda_oe), 16'h0);
        bus_stop();
        chk("rd_final_addr", 16'(reg_addr), 16'h12);
        chk("rd_no_we", 16'(we_log.size()), 16'd2);
        chk("rd_busy_after_stop", 16'(busy), 16'h0);

        // Address mismatch
        busy_seen = 1'b0;
        bus_start();
        write_byte(8'h36, ack);
        chk("mm_no_ack", 16'(ack), 16'h0);
        write_byte(8'h55, ack);
        chk("mm_data_no_ack", 16'(ack), 16'h0);
        write_byte(8'h66, ack);
        bus_stop();
        chk("mm_no_we", 16'(we_log.size()), 16'd2);
        chk("mm_busy_never", 16'(busy_seen), 16'h0);
        chk("mm_addr_kept", 16'(reg_addr), 16'h12);

        // Pointer wrap
        bus_start();
        write_byte(8'h34, ack);
        write_byte(8'hFF, ack);
        chk("wrap_ptr", 16'(reg_addr), 16'hFF);
        write_byte(8'h11, ack);
        chk("wrap_d0_ack", 16'(ack), 16'h1);
        write_byte(8'h22, ack);
        bus_stop();
        chk("wrap_we_count", 16'(we_log.size()), 16'd4);
        chk("wrap_we0", we_log[2], 16'hFF11);
        chk("wrap_we1", we_log[3], 16'h0022);
        chk("wrap_final_addr", 16'(reg_addr), 16'h01);

        // STOP after 4 data bits
        bus_start();
        write_byte(8'h34, ack);
        write_byte(8'h20, ack);
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_bit(1'b1, s);
        bus_bit(1'b0, s);
        bus_stop();
        chk("abort_no_we", 16'(we_log.size()), 16'd4);
        chk("abort_sda_oe", 16'(sda_oe), 16'h0);
        chk("abort_busy", 16'(busy), 16'h0);
        chk("abort_addr", 16'(reg_addr), 16'h20);

        // Async reset while the address ACK is being driven
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(((8'h34 >> i) & 8'h01) != 8'h00, s);
        repeat (2 * Q) @(negedge clk);
        chk("ack_driven_before_rst", 16'(sda_oe), 16'h1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_sda_oe", 16'(sda_oe), 16'h0);
        chk("async_rst_busy", 16'(busy), 16'h0);
        chk("async_rst_addr", 16'(reg_addr), 16'h00);
        scl = 1'b1;
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("final_idle_sda_oe", 16'(sda_oe), 16'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
